// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter and its address decoder.
package bus_pkg;

  typedef enum logic {M0, M1} mst_e;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 29;
  localparam int REGION_W = REGION_MSB - REGION_LSB + 1;
  localparam logic [31:0] DECERR_VALUE = 32'hDEADBEEF;

endpackage

// File: rtl/bus_decode.sv
// Address decoder: top address bits select one of N_SLV regions; higher regions are unmapped.
module bus_decode
  import bus_pkg::*;
#(
  parameter int N_SLV = 3
) (
  input  logic [31:0]         addr,
  output logic [N_SLV-1:0]    sel,
  output logic [REGION_W-1:0] region,
  output logic                mapped
);

  logic unused_addr_low;
  assign unused_addr_low = ^addr[REGION_LSB-1:0];

  always_comb begin
    region = addr[REGION_MSB:REGION_LSB];
    mapped = (int'(region) < N_SLV);
    sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      sel[i] = (region == REGION_W'(i));
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with burst cap, region decode and read-return routing.
// Optional decode-error reporting is enabled with the BUS_ARB_DECERR_EN macro.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_SLV     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m0_req_i,
  input  logic [3:0]         m0_wstrb_i,
  input  logic [31:0]        m0_addr_i,
  input  logic [31:0]        m0_wvalue_i,
  output logic               m0_gnt_o,
  output logic               m0_rvalid_o,
  output logic [31:0]        m0_rvalue_o,
  input  logic               m1_req_i,
  input  logic [3:0]         m1_wstrb_i,
  input  logic [31:0]        m1_addr_i,
  input  logic [31:0]        m1_wvalue_i,
  output logic               m1_gnt_o,
  output logic               m1_rvalid_o,
  output logic [31:0]        m1_rvalue_o,
  output logic               s_enable_o,
  output logic [N_SLV-1:0]   s_sel_o,
  output logic [3:0]         s_wstrb_o,
  output logic [31:0]        s_addr_o,
  output logic [31:0]        s_wvalue_o,
  input  logic [32*N_SLV-1:0] s_rvalue_i,
`ifdef BUS_ARB_DECERR_EN
  output logic               dec_err_o,
`endif
  output arb_state_e         state_o
);

  // Handshake: a master holds req with stable fields until gnt is seen high in the
  // same cycle; the access is then consumed, and a read answers with rvalid one cycle later.

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((MAX_BURST == 0) ? 255 : MAX_BURST);

  arb_state_e state;
  mst_e last, owner, gnt_id, rmst_q;
  logic [CNT_W-1:0] burst_cnt;
  logic gnt_any, cap_hit, rd_q, rmapped_q, mapped;
  logic [REGION_W-1:0] rsel_q, region;
  logic [N_SLV-1:0] sel;
  logic [3:0] mux_wstrb;
  logic [31:0] mux_addr, mux_wvalue, rdata;

  assign owner = (state == OWN1) ? M1 : M0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id = M0;
    cap_hit = (MAX_BURST != 0) && (burst_cnt >= CNT_SAT);
    unique case (state)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          gnt_any = 1'b1;
          gnt_id = (last == M0) ? M1 : M0;
        end else if (m0_req_i || m1_req_i) begin
          gnt_any = 1'b1;
          gnt_id = m1_req_i ? M1 : M0;
        end
      end
      OWN0: begin
        if (m0_req_i && (!m1_req_i || !cap_hit)) begin
          gnt_any = 1'b1;
          gnt_id = M0;
        end else if (m1_req_i) begin
          gnt_any = 1'b1;
          gnt_id = M1;
        end
      end
      OWN1: begin
        if (m1_req_i && (!m0_req_i || !cap_hit)) begin
          gnt_any = 1'b1;
          gnt_id = M1;
        end else if (m0_req_i) begin
          gnt_any = 1'b1;
          gnt_id = M0;
        end
      end
      default: ;
    endcase
    if (rst_i) gnt_any = 1'b0;
  end

  always_comb begin
    mux_wstrb = (gnt_id == M1) ? m1_wstrb_i : m0_wstrb_i;
    mux_addr = (gnt_id == M1) ? m1_addr_i : m0_addr_i;
    mux_wvalue = (gnt_id == M1) ? m1_wvalue_i : m0_wvalue_i;
  end

  bus_decode #(.N_SLV(N_SLV)) u_decode (
    .addr   (mux_addr),
    .sel    (sel),
    .region (region),
    .mapped (mapped)
  );

  assign m0_gnt_o = gnt_any && (gnt_id == M0);
  assign m1_gnt_o = gnt_any && (gnt_id == M1);
  // Unmapped accesses are granted (consumed) but never strobe a slave.
  assign s_enable_o = gnt_any && mapped;
  assign s_sel_o = gnt_any ? sel : '0;
  assign s_wstrb_o = gnt_any ? mux_wstrb : '0;
  assign s_addr_o = gnt_any ? mux_addr : '0;
  assign s_wvalue_o = gnt_any ? mux_wvalue : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last <= M1;
      burst_cnt <= '0;
      rd_q <= 1'b0;
      rmst_q <= M0;
      rsel_q <= '0;
      rmapped_q <= 1'b0;
    end else begin
      rd_q <= gnt_any && (mux_wstrb == 4'b0000);
      if (gnt_any) begin
        state <= (gnt_id == M1) ? OWN1 : OWN0;
        last <= gnt_id;
        rmst_q <= gnt_id;
        rsel_q <= region;
        rmapped_q <= mapped;
        if (state == IDLE || gnt_id != owner) begin
          burst_cnt <= CNT_W'(1);
        end else if (burst_cnt < CNT_SAT) begin
          burst_cnt <= burst_cnt + CNT_W'(1);
        end
      end else begin
        state <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (rsel_q == REGION_W'(i)) rdata = s_rvalue_i[32*i +: 32];
    end
`ifdef BUS_ARB_DECERR_EN
    if (!rmapped_q) rdata = DECERR_VALUE;
`else
    if (!rmapped_q) rdata = '0;
`endif
  end

  assign m0_rvalid_o = !rst_i && rd_q && (rmst_q == M0);
  assign m1_rvalid_o = !rst_i && rd_q && (rmst_q == M1);
  assign m0_rvalue_o = rdata;
  assign m1_rvalue_o = rdata;
  assign state_o = state;

`ifdef BUS_ARB_DECERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_err_o <= 1'b0;
    end else if (gnt_any && !mapped) begin
      dec_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: rule-level grant/response model checked every cycle,
// plus literal expectations per scenario.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int N_SLV = 3;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m1_req;
  logic [3:0] m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wvalue, m1_wvalue;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rvalue, m1_rvalue;
  logic s_enable;
  logic [N_SLV-1:0] s_sel;
  logic [3:0] s_wstrb;
  logic [31:0] s_addr, s_wvalue;
  logic [32*N_SLV-1:0] s_rvalue;
  arb_state_e state;
`ifdef BUS_ARB_DECERR_EN
  logic dec_err;
  localparam logic [31:0] UNMAPPED_VAL = 32'hDEADBEEF;
`else
  localparam logic [31:0] UNMAPPED_VAL = 32'h0;
`endif

  logic [31:0] slot_val [N_SLV] = '{32'h11111111, 32'h22222222, 32'h33333333};
  assign s_rvalue = {slot_val[2], slot_val[1], slot_val[0]};

  always #5 clk = ~clk;

  bus_arbiter #(.N_SLV(N_SLV), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_wstrb_i(m0_wstrb), .m0_addr_i(m0_addr), .m0_wvalue_i(m0_wvalue),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rvalue_o(m0_rvalue),
    .m1_req_i(m1_req), .m1_wstrb_i(m1_wstrb), .m1_addr_i(m1_addr), .m1_wvalue_i(m1_wvalue),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rvalue_o(m1_rvalue),
    .s_enable_o(s_enable), .s_sel_o(s_sel), .s_wstrb_o(s_wstrb), .s_addr_o(s_addr),
    .s_wvalue_o(s_wvalue), .s_rvalue_i(s_rvalue),
`ifdef BUS_ARB_DECERR_EN
    .dec_err_o(dec_err),
`endif
    .state_o(state)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the bus, how long its current run is, who won last.
  int holder = -1;
  int run_len = 0;
  int last_won = 1;
  logic m_dec_err = 1'b0;
  logic [31:0] exp_q[$];
  int exp_mst_q[$];

  function automatic int pick(logic r0, logic r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    if (holder < 0) return 1 - last_won;
    if (MAX_BURST != 0 && run_len >= MAX_BURST) return 1 - holder;
    return holder;
  endfunction

  int win, rgn, e_mst;
  logic e_rv0, e_rv1;
  logic [31:0] e_val, w_addr, w_wvalue;
  logic [3:0] w_wstrb;
  logic [N_SLV-1:0] e_sel;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h0);
      chk("rst_enable", s_enable, 1'b0);
      chk("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
      holder = -1;
      run_len = 0;
      last_won = 1;
      m_dec_err = 1'b0;
      exp_q.delete();
      exp_mst_q.delete();
    end else begin
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      e_val = '0;
      if (exp_q.size() > 0) begin
        e_val = exp_q.pop_front();
        e_mst = exp_mst_q.pop_front();
        e_rv0 = (e_mst == 0);
        e_rv1 = (e_mst == 1);
      end
      chk("m0_rvalid", m0_rvalid, e_rv0);
      chk("m1_rvalid", m1_rvalid, e_rv1);
      if (e_rv0) chk("m0_rvalue", m0_rvalue, e_val);
      if (e_rv1) chk("m1_rvalue", m1_rvalue, e_val);
`ifdef BUS_ARB_DECERR_EN
      chk("dec_err", dec_err, m_dec_err);
`endif
      win = pick(m0_req, m1_req);
      w_addr = (win == 1) ? m1_addr : m0_addr;
      w_wstrb = (win == 1) ? m1_wstrb : m0_wstrb;
      w_wvalue = (win == 1) ? m1_wvalue : m0_wvalue;
      rgn = int'(w_addr[31:29]);
      chk("m0_gnt", m0_gnt, win == 0);
      chk("m1_gnt", m1_gnt, win == 1);
      if (win < 0) begin
        chk("idle_enable", s_enable, 1'b0);
        chk("idle_fields", s_addr | s_wvalue | {28'b0, s_wstrb} | {29'b0, s_sel}, 32'h0);
        holder = -1;
        run_len = 0;
      end else begin
        e_sel = '0;
        if (rgn < N_SLV) e_sel[rgn] = 1'b1;
        chk("s_enable", s_enable, rgn < N_SLV);
        chk("s_sel", s_sel, e_sel);
        chk("s_addr", s_addr, w_addr);
        chk("s_wstrb", s_wstrb, w_wstrb);
        chk("s_wvalue", s_wvalue, w_wvalue);
        if (w_wstrb == 4'b0000) begin
          exp_q.push_back((rgn < N_SLV) ? slot_val[rgn] : UNMAPPED_VAL);
          exp_mst_q.push_back(win);
        end
        if (rgn >= N_SLV) m_dec_err = 1'b1;
        run_len = (win == holder) ? run_len + 1 : 1;
        holder = win;
        last_won = win;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(logic r, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    m0_req = r; m0_wstrb = w; m0_addr = a; m0_wvalue = d;
  endtask

  task automatic set_m1(logic r, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    m1_req = r; m1_wstrb = w; m1_addr = a; m1_wvalue = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_m0(0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 4'h0, 32'h0, 32'h0);
    repeat (2) next_cycle();

    // 1: simultaneous reads after reset, M0 wins the first tie
    next_cycle();
    rst = 1'b0;
    set_m0(1, 4'h0, 32'h0000_0000, 32'h0);
    set_m1(1, 4'h0, 32'h2000_0000, 32'h0);
    @(negedge clk);
    chk("t1_c0_gnt0", m0_gnt, 1'b1);
    chk("t1_c0_gnt1", m1_gnt, 1'b0);
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_c1_gnt1", m1_gnt, 1'b1);
    chk("t1_c1_rvalid0", m0_rvalid, 1'b1);
    chk("t1_c1_rvalue0", m0_rvalue, 32'h11111111);
    next_cycle();
    set_m1(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_c2_rvalid1", m1_rvalid, 1'b1);
    chk("t1_c2_rvalue1", m1_rvalue, 32'h22222222);
    chk("t1_c2_rvalid0", m0_rvalid, 1'b0);

    // 2: burst cap of 4 forces a handover to the waiting M1
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      set_m0(1, 4'h0, 32'h0000_0004, 32'h0);
      set_m1((c >= 1) && (c <= 4), 4'h0, 32'h4000_0000, 32'h0);
      @(negedge clk);
      chk("t2_gnt0", m0_gnt, c != 4);
      chk("t2_gnt1", m1_gnt, c == 4);
    end
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 4'h0, 32'h0, 32'h0);

    // 3: write to region 1, no read response
    next_cycle();
    set_m0(1, 4'b0011, 32'h2000_0010, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t3_sel", s_sel, 3'b010);
    chk("t3_wstrb", s_wstrb, 4'b0011);
    chk("t3_wvalue", s_wvalue, 32'hCAFE_F00D);
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t3_no_rvalid", {31'b0, m0_rvalid | m1_rvalid}, 32'h0);

    // tie from IDLE after M0 last won goes to M1, then M0 follows
    next_cycle();
    set_m0(1, 4'b1111, 32'h4000_0020, 32'hAAAA_0000);
    set_m1(1, 4'b1000, 32'h0000_0030, 32'hBBBB_0000);
    @(negedge clk);
    chk("tie_gnt1", m1_gnt, 1'b1);
    chk("tie_wvalue", s_wvalue, 32'hBBBB_0000);
    next_cycle();
    set_m1(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("tie_next_gnt0", m0_gnt, 1'b1);
    chk("tie_next_sel", s_sel, 3'b100);
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);

    // 4: alternating back-to-back reads keep their own return owner
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      set_m0((c == 0) || (c == 2), 4'h0, 32'h0000_0000, 32'h0);
      set_m1((c == 1) || (c == 3), 4'h0, 32'h2000_0000, 32'h0);
      @(negedge clk);
      if (c >= 1) begin
        chk("t4_rvalid0", m0_rvalid, (c % 2) == 1);
        chk("t4_rvalid1", m1_rvalid, (c % 2) == 0);
        chk("t4_rvalue", (c % 2 == 1) ? m0_rvalue : m1_rvalue,
            (c % 2 == 1) ? 32'h11111111 : 32'h22222222);
      end
    end

    // 5: unmapped region read
    next_cycle();
    set_m0(1, 4'h0, 32'hE000_0000, 32'h0);
    @(negedge clk);
    chk("t5_gnt0", m0_gnt, 1'b1);
    chk("t5_enable", s_enable, 1'b0);
    chk("t5_sel", s_sel, 3'b000);
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_rvalid", m0_rvalid, 1'b1);
    chk("t5_rvalue", m0_rvalue, UNMAPPED_VAL);
`ifdef BUS_ARB_DECERR_EN
    chk("t5_dec_err", dec_err, 1'b1);
`endif

    // 6: reset right after a granted read drops the response
    next_cycle();
    set_m1(1, 4'h0, 32'h4000_0000, 32'h0);
    @(negedge clk);
    chk("t6_gnt1", m1_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    set_m1(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t6_rst_rvalid1", m1_rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;
    set_m0(1, 4'h0, 32'h4000_0008, 32'h0);
    set_m1(1, 4'h0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    chk("t6_state", 32'(state), 32'(IDLE));
    chk("t6_rvalid1", m1_rvalid, 1'b0);
    chk("t6_tie_gnt0", m0_gnt, 1'b1);
    chk("t6_tie_gnt1", m1_gnt, 1'b0);
`ifdef BUS_ARB_DECERR_EN
    chk("t6_dec_err_clr", dec_err, 1'b0);
`endif
    next_cycle();
    set_m0(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t6_next_gnt1", m1_gnt, 1'b1);
    next_cycle();
    set_m1(0, 4'h0, 32'h0, 32'h0);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
